// File: rtl/alu_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mac_sequencer_pkg
// Description : Shared definitions for the ALU multiply-accumulate sequencer:
//               default widths, ALU opcode constants and the FSM state
//               encoding used by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mac_sequencer_pkg;

  // Default datapath and vector-length widths
  localparam int C_DATA_W_DEFAULT = 24;
  localparam int C_LEN_W_DEFAULT  = 8;

  // ALU opcodes understood by the external combinational ALU.
  // The sequencer only ever issues ADD and MUL; the others are listed so
  // the whole opcode space of the ALU lives in one place.
  localparam logic [2:0] C_ALU_ADD = 3'd0;
  localparam logic [2:0] C_ALU_SUB = 3'd1;
  localparam logic [2:0] C_ALU_MUL = 3'd2;
  localparam logic [2:0] C_ALU_SHR = 3'd3;
  localparam logic [2:0] C_ALU_INC = 3'd4;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage : alu_mac_sequencer_pkg
`default_nettype wire

// File: rtl/alu_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_mac_sequencer_if
// Description : Bundles the command, operand-stream, ALU and status signals
//               of the MAC sequencer.
//               master : the parent side (issues start, streams operands,
//                        hosts the combinational ALU, observes status).
//               slave  : the sequencer itself.
// Signals     : start, length          - command (length sampled with start)
//               op_valid/op_ready,
//               a_data, b_data         - operand-pair stream
//               alu_ctrl, alu_a, alu_b - ALU request (sequencer -> ALU)
//               alu_c, alu_z           - ALU result and zero flag
//               busy, done, result,
//               zero_flag              - status and final value
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_mac_sequencer_if
  import alu_mac_sequencer_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT,
  parameter int LEN_W  = C_LEN_W_DEFAULT
) ();

  // Command
  logic              start;
  logic [LEN_W-1:0]  length;

  // Operand stream
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;

  // ALU request / response
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic              alu_z;

  // Status
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero_flag;

  modport master (
    output start, length, op_valid, a_data, b_data, alu_c, alu_z,
    input  op_ready, alu_ctrl, alu_a, alu_b, busy, done, result, zero_flag
  );

  modport slave (
    input  start, length, op_valid, a_data, b_data, alu_c, alu_z,
    output op_ready, alu_ctrl, alu_a, alu_b, busy, done, result, zero_flag
  );

endinterface : alu_mac_sequencer_if
`default_nettype wire

// File: rtl/alu_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_mac_sequencer
// Description : Computes a dot product sum(a[i]*b[i]) of 'length' operand
//               pairs by sequencing an external combinational ALU through
//               MUL and ADD operations. Each element takes three cycles
//               (FETCH, MUL, ADD) plus any cycles spent waiting for op_valid.
//               All arithmetic wraps modulo 2^DATA_W as the ALU produces it.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               bus.slave - command, operand stream, ALU request/response
//                           and status (see alu_mac_sequencer_if)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mac_sequencer
  import alu_mac_sequencer_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT,
  parameter int LEN_W  = C_LEN_W_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_mac_sequencer_if.slave bus
);

  localparam logic [LEN_W-1:0] C_CNT_ONE = LEN_W'(1);

  seq_state_t        r_state;
  logic [LEN_W-1:0]  r_cnt;        // elements still to accumulate
  logic [DATA_W-1:0] r_acc;        // running accumulator
  logic              r_z;          // alu_z from the most recent ADD
  logic [DATA_W-1:0] r_result;
  logic              r_zero_flag;
  logic              r_done;
  logic              r_busy;
  logic              r_op_ready;
  logic [2:0]        r_alu_ctrl;
  // The ALU operand registers hold the captured pair (a_reg/b_reg) while in
  // MUL and {acc, prod} while in ADD, so the operand pair and the product
  // need no separate storage: the product is captured straight into r_alu_b.
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  // --------------------------------------------------------------------------
  // FSM and datapath. Every output is a register, loaded on the transition
  // into the state where it must be valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_z         <= 1'b0;
      r_result    <= '0;
      r_zero_flag <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_op_ready  <= 1'b0;
      r_alu_ctrl  <= C_ALU_ADD;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else begin
      // done is a single-cycle pulse; it is only set on entry to DONE
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt  <= bus.length;
            r_acc  <= '0;
            // An empty vector leaves the accumulator at zero, so its zero
            // flag must read as set.
            r_z    <= 1'b1;
            r_busy <= 1'b1;
            if (bus.length != '0) begin
              r_state    <= S_FETCH;
              r_op_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (bus.op_valid && r_op_ready) begin
            r_op_ready <= 1'b0;
            r_alu_ctrl <= C_ALU_MUL;
            r_alu_a    <= bus.a_data;
            r_alu_b    <= bus.b_data;
            r_state    <= S_MUL;
          end
        end

        S_MUL: begin
          // alu_c is the product; present {acc, prod} for the ADD
          r_alu_ctrl <= C_ALU_ADD;
          r_alu_a    <= r_acc;
          r_alu_b    <= bus.alu_c;
          r_state    <= S_ADD;
        end

        S_ADD: begin
          r_acc   <= bus.alu_c;
          r_z     <= bus.alu_z;
          r_cnt   <= r_cnt - C_CNT_ONE;
          r_alu_a <= '0;
          r_alu_b <= '0;
          if (r_cnt == C_CNT_ONE) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_op_ready <= 1'b1;
          end
        end

        S_DONE: begin
          r_result    <= r_acc;
          r_zero_flag <= r_z;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_op_ready <= 1'b0;
          r_alu_ctrl <= C_ALU_ADD;
          r_alu_a    <= '0;
          r_alu_b    <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.op_ready  = r_op_ready;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.zero_flag = r_zero_flag;

endmodule : alu_mac_sequencer
`default_nettype wire

// File: tb/tb_alu_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_mac_sequencer
// Description : Self-checking bench for alu_mac_sequencer. Hosts a
//               behavioural combinational ALU, streams operand pairs and
//               compares latency, result and flags against values computed
//               directly from the dot-product definition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mac_sequencer;
  import alu_mac_sequencer_pkg::*;

  localparam int DW   = 24;
  localparam int LW   = 8;
  localparam int MAXN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mac_sequencer_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  alu_mac_sequencer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU
  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = a * b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[DW-1:0];
      3'd3:    return a >> b[4:0];
      3'd4:    return a + DW'(1);
      default: return '0;
    endcase
  endfunction

  assign bus.alu_c = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_z = (bus.alu_c == '0);

  // Operand stream for the current run: pair i is offered after op_st[i]
  // op_valid-low cycles in which the sequencer is ready.
  logic [DW-1:0] op_a [MAXN];
  logic [DW-1:0] op_b [MAXN];
  int            op_st[MAXN];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One complete dot-product run. inject_at >= 0 issues an extra start
  // (length 9) at that cycle of the run, which must be ignored.
  task automatic do_run(input string tag, input int len, input int inject_at,
                        input logic [DW-1:0] exp_res, input bit exp_z, input int exp_lat);
    int done_edge, pulses, idx, stall_left;
    bit ready_seen;
    done_edge  = -1;
    pulses     = 0;
    idx        = 0;
    ready_seen = 1'b0;
    stall_left = op_st[0];

    @(negedge clk);
    bus.start    = 1'b1;
    bus.length   = LW'(len);
    // junk pair offered while idle: must not be consumed
    bus.op_valid = 1'b1;
    bus.a_data   = DW'($urandom);
    bus.b_data   = DW'($urandom);

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);   // sample after edge k (edge 0 samples start)
      bus.start  = (k == inject_at);
      bus.length = (k == inject_at) ? LW'(9) : LW'($urandom);
      if (bus.op_ready) ready_seen = 1'b1;
      if (bus.done) begin
        pulses++;
        if (done_edge < 0) done_edge = k;
      end
      if (done_edge >= 0 && k >= done_edge + 3) break;
      if (bus.op_ready && idx < len) begin
        if (stall_left > 0) begin
          bus.op_valid = 1'b0;
          stall_left--;
        end else begin
          bus.op_valid = 1'b1;
          bus.a_data   = op_a[idx];
          bus.b_data   = op_b[idx];
          idx++;
          if (idx < MAXN) stall_left = op_st[idx];
        end
      end else begin
        bus.op_valid = 1'b1;
        bus.a_data   = DW'($urandom);
        bus.b_data   = DW'($urandom);
      end
    end
    bus.start    = 1'b0;
    bus.op_valid = 1'b0;

    check({tag, " latency"},   64'(done_edge), 64'(exp_lat));
    check({tag, " done_count"}, 64'(pulses),   64'd1);
    check({tag, " consumed"},  64'(idx),       64'(len));
    check({tag, " result"},    64'(bus.result), 64'(exp_res));
    check({tag, " zero_flag"}, 64'(bus.zero_flag), 64'(exp_z));
    check({tag, " busy_after"}, 64'(bus.busy),  64'd0);
    check({tag, " op_ready_seen"}, 64'(ready_seen), 64'(len != 0));
  endtask

  typedef struct {
    int                  len;
    logic [3:0][DW-1:0]  a;
    logic [3:0][DW-1:0]  b;
    logic [3:0][7:0]     st;
    logic [DW-1:0]       er;
    bit                  ez;
    int                  el;
  } vec_t;

  vec_t tbl[6];

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      64'(bus.busy),      64'd0);
    check({tag, " done"},      64'(bus.done),      64'd0);
    check({tag, " op_ready"},  64'(bus.op_ready),  64'd0);
    check({tag, " result"},    64'(bus.result),    64'd0);
    check({tag, " zero_flag"}, 64'(bus.zero_flag), 64'd0);
    check({tag, " alu_ctrl"},  64'(bus.alu_ctrl),  64'(C_ALU_ADD));
    check({tag, " alu_a"},     64'(bus.alu_a),     64'd0);
    check({tag, " alu_b"},     64'(bus.alu_b),     64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] sum;
    int          len, lat, pulses;

    bus.start    = 1'b0;
    bus.length   = '0;
    bus.op_valid = 1'b0;
    bus.a_data   = '0;
    bus.b_data   = '0;
    for (int j = 0; j < MAXN; j++) begin
      op_a[j] = '0; op_b[j] = '0; op_st[j] = 0;
    end

    // ---------------- reset state ----------------
    rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- table vectors ----------------
    tbl[0].len = 3; tbl[0].a = {24'd0, 24'd5, 24'd3, 24'd1};
    tbl[0].b = {24'd0, 24'd6, 24'd4, 24'd2}; tbl[0].st = '0;
    tbl[0].er = 24'd44; tbl[0].ez = 1'b0; tbl[0].el = 9;

    tbl[1].len = 0; tbl[1].a = '0; tbl[1].b = '0; tbl[1].st = '0;
    tbl[1].er = 24'd0; tbl[1].ez = 1'b1; tbl[1].el = 0;

    tbl[2].len = 2; tbl[2].a = {24'd0, 24'd0, 24'd2, 24'd7};
    tbl[2].b = {24'd0, 24'd0, 24'd2, 24'd3}; tbl[2].st = {8'd0, 8'd0, 8'd5, 8'd0};
    tbl[2].er = 24'd25; tbl[2].ez = 1'b0; tbl[2].el = 11;

    tbl[3].len = 2; tbl[3].a = {24'd0, 24'd0, 24'd1, 24'hFFFFFF};
    tbl[3].b = {24'd0, 24'd0, 24'd1, 24'd1}; tbl[3].st = '0;
    tbl[3].er = 24'd0; tbl[3].ez = 1'b1; tbl[3].el = 6;

    tbl[4].len = 1; tbl[4].a = {24'd0, 24'd0, 24'd0, 24'd0};
    tbl[4].b = {24'd0, 24'd0, 24'd0, 24'd5}; tbl[4].st = '0;
    tbl[4].er = 24'd0; tbl[4].ez = 1'b1; tbl[4].el = 3;

    tbl[5].len = 4; tbl[5].a = {24'h000001, 24'd0, 24'd3, 24'h800000};
    tbl[5].b = {24'h7FFFFF, 24'd7, 24'd3, 24'd2}; tbl[5].st = {8'd0, 8'd2, 8'd0, 8'd1};
    tbl[5].er = 24'h800008; tbl[5].ez = 1'b0; tbl[5].el = 15;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < MAXN; j++) begin
        op_a[j]  = (j < 4) ? tbl[i].a[j] : '0;
        op_b[j]  = (j < 4) ? tbl[i].b[j] : '0;
        op_st[j] = (j < 4) ? int'(tbl[i].st[j]) : 0;
      end
      do_run($sformatf("vec%0d", i), tbl[i].len, -1, tbl[i].er, tbl[i].ez, tbl[i].el);
    end

    // ---------------- start while busy is ignored ----------------
    op_a[0] = 24'd6; op_b[0] = 24'd6; op_st[0] = 0;
    do_run("busy_start", 1, 1, 24'd36, 1'b0, 3);

    // ---------------- reset in MUL of element 2 of 4 ----------------
    @(negedge clk);
    bus.start    = 1'b1;
    bus.length   = LW'(4);
    bus.op_valid = 1'b1;
    bus.a_data   = 24'd10;
    bus.b_data   = 24'd11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 2) begin
        bus.a_data = 24'd12;
        bus.b_data = 24'd13;
      end
    end
    check("midrun alu_ctrl", 64'(bus.alu_ctrl), 64'(C_ALU_MUL));
    check("midrun alu_a",    64'(bus.alu_a),    64'd12);
    check("midrun busy",     64'(bus.busy),     64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    rst = 1'b0;
    bus.op_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("reset no_done", 64'(pulses), 64'd0);
    op_a[0] = 24'd4; op_b[0] = 24'd5; op_st[0] = 0;
    do_run("after_reset", 1, -1, 24'd20, 1'b0, 3);

    // ---------------- randomized runs against the dot-product model ----------------
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 6);
      sum = '0;
      lat = 0;
      for (int j = 0; j < MAXN; j++) begin
        op_a[j]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
        op_b[j]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
        op_st[j] = $urandom_range(0, 3);
      end
      for (int j = 0; j < len; j++) begin
        sum = sum + 64'(op_a[j]) * 64'(op_b[j]);
        lat = lat + 3 + op_st[j];
      end
      do_run($sformatf("rand%0d", r), len, -1, sum[DW-1:0], (sum[DW-1:0] == '0), lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_mac_sequencer
`default_nettype wire
